// File: rtl/spi_slave_param.sv
// SPI slave front-end for the single-port RAM path: MOSI/SS_n sampled on clk, payloads to RAM, read data out on MISO.
// Optional odd-parity bit after the payload when SPI_PARITY_EN is defined.
module spi_slave_param #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              MISO,
  output logic              rx_valid,
  output logic [DATA_W+1:0] rx_data,
  output logic              frame_err,
  output logic              busy
);

  localparam int PAY_W = DATA_W + 2;
  localparam int CNT_W = $clog2(PAY_W + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;
  localparam logic [2:0] WAIT_TX   = 3'd5;
  localparam logic [2:0] SEND      = 3'd6;
  localparam logic [2:0] DONE      = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PAY_W-1:0]  rx_data_q, rx_data_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              addr_pending_q, addr_pending_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              last_bit, parity_ok;

`ifdef SPI_PARITY_EN
  // Counter reaches zero with the payload complete; this cycle carries the parity bit.
  assign last_bit  = (cnt_q == '0);
  assign parity_ok = ^{rx_data_q, MOSI};
`else
  assign last_bit  = (cnt_q == CNT_W'(1));
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    // NOTE: every _d gets a default first so no latches are inferred.
    state_d        = state_q;
    cnt_d          = cnt_q;
    rx_data_d      = rx_data_q;
    tx_shift_d     = tx_shift_q;
    addr_pending_d = addr_pending_q;
    rx_valid_d     = 1'b0;
    frame_err_d    = 1'b0;
    case (state_q)
      IDLE: if (!SS_n) state_d = CHK_CMD;
      CHK_CMD: begin
        if (SS_n) begin
          state_d = IDLE;
        end else begin
          cnt_d = CNT_W'(PAY_W);
          if (!MOSI)               state_d = WRITE;
          else if (addr_pending_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else begin
          if (cnt_q != '0) begin
            rx_data_d[cnt_q - 1'b1] = MOSI;
            cnt_d                   = cnt_q - 1'b1;
          end
          if (last_bit) begin
            if (!parity_ok) begin
              frame_err_d = 1'b1;
              state_d     = DONE;
            end else begin
              rx_valid_d = 1'b1;
              case (state_q)
                READ_ADD: begin
                  addr_pending_d = 1'b1;
                  state_d        = DONE;
                end
                READ_DATA: state_d = WAIT_TX;
                default:   state_d = DONE;
              endcase
            end
          end
        end
      end
      WAIT_TX: begin
        // SS_n outranks tx_valid so a late read result is dropped, not latched.
        if (SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (tx_valid) begin
          tx_shift_d = tx_data;
          cnt_d      = CNT_W'(DATA_W);
          state_d    = SEND;
        end
      end
      SEND: begin
        if (SS_n) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else begin
          tx_shift_d = tx_shift_q << 1;
          cnt_d      = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            addr_pending_d = 1'b0;
            state_d        = DONE;
          end
        end
      end
      DONE:    if (SS_n) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rx_data_q      <= '0;
      tx_shift_q     <= '0;
      addr_pending_q <= 1'b0;
      rx_valid_q     <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rx_data_q      <= rx_data_d;
      tx_shift_q     <= tx_shift_d;
      addr_pending_q <= addr_pending_d;
      rx_valid_q     <= rx_valid_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign MISO      = (state_q == SEND) ? tx_shift_q[DATA_W-1] : 1'b0;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: expected payloads are queued at stimulus time and popped on rx_valid.
module tb_spi_slave_param;

  localparam int DATA_W = 8;
  localparam int PAY_W  = DATA_W + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              SS_n = 1'b1;
  logic              MOSI = 1'b0;
  logic              tx_valid = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              MISO;
  logic              rx_valid;
  logic [PAY_W-1:0]  rx_data;
  logic              frame_err;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int rx_count = 0;
  int ferr_count = 0;
  int miso_ones = 0;
  logic [PAY_W-1:0] exp_q[$];

  spi_slave_param #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
    .tx_valid(tx_valid), .tx_data(tx_data), .MISO(MISO),
    .rx_valid(rx_valid), .rx_data(rx_data), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives SS_n low, the command bit and the first nbits payload bits MSB-first; SS_n is left low.
  task automatic frame(input bit cmd, input logic [PAY_W-1:0] pay, input int nbits, input bit par_good);
    SS_n = 1'b0;
    tick();
    MOSI = cmd;
    tick();
    for (int i = PAY_W - 1; i >= PAY_W - nbits; i--) begin
      MOSI = pay[i];
      tick();
    end
`ifdef SPI_PARITY_EN
    if (nbits == PAY_W) begin
      MOSI = par_good ? ~(^pay) : ^pay;
      tick();
    end
`else
    if (par_good && nbits > PAY_W) $display("note: parity bit not used in this build");
`endif
  endtask

  task automatic release_ss();
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (MISO === 1'b1) miso_ones++;
      if (frame_err === 1'b1) ferr_count++;
      if (rx_valid === 1'b1) begin
        rx_count++;
        if (exp_q.size() == 0) check("rx_unexpected", exp_q.size(), 1);
        else check("rx_data", rx_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rxc, fec, mo;
    logic [7:0] rd;

    // Reset state
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_miso", MISO, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_addr_pending", dut.addr_pending_q, 0);

    // 1. Write frame
    rxc = rx_count; mo = miso_ones;
    exp_q.push_back(10'h0A5);
    frame(1'b0, 10'h0A5, PAY_W, 1'b1);
    @(negedge clk);
    check("wr_rx_valid_hi", rx_valid, 1);
    check("wr_rx_data", rx_data, 10'h0A5);
    @(negedge clk);
    check("wr_rx_valid_pulse", rx_valid, 0);
    check("wr_rx_data_hold", rx_data, 10'h0A5);
    check("wr_addr_pending", dut.addr_pending_q, 0);
    check("wr_busy_done", busy, 1);
    release_ss();
    check("wr_rx_count", rx_count - rxc, 1);
    check("wr_miso_quiet", miso_ones - mo, 0);

    // 2. Read-address then read-data with C3 shifted out
    exp_q.push_back(10'h233);
    frame(1'b1, 10'h233, PAY_W, 1'b1);
    @(negedge clk);
    check("ra_addr_pending", dut.addr_pending_q, 1);
    release_ss();
    tick();
    mo = miso_ones;
    exp_q.push_back(10'h300);
    frame(1'b1, 10'h300, PAY_W, 1'b1);
    tick();
    tick();
    check("rd_wait_busy", busy, 1);
    check("rd_wait_miso", MISO, 0);
    tx_valid = 1'b1; tx_data = 8'hC3;
    tick();
    tx_valid = 1'b0; tx_data = 8'h00;
    rd = 8'hC3;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      @(negedge clk);
      check($sformatf("rd_miso_bit%0d", i), MISO, rd[i]);
    end
    @(negedge clk);
    check("rd_miso_after", MISO, 0);
    check("rd_addr_cleared", dut.addr_pending_q, 0);
    check("rd_miso_ones", miso_ones - mo, 4);
    release_ss();

    // 3. Abort after 5 payload bits
    rxc = rx_count; fec = ferr_count;
    frame(1'b0, 10'h155, 5, 1'b1);
    SS_n = 1'b1;
    tick();
    @(negedge clk);
    check("ab_frame_err", frame_err, 1);
    check("ab_busy", busy, 0);
    @(negedge clk);
    check("ab_frame_err_pulse", frame_err, 0);
    check("ab_rx_count", rx_count - rxc, 0);
    check("ab_ferr_count", ferr_count - fec, 1);
    check("ab_addr_pending", dut.addr_pending_q, 0);

    // 4. Reset during SEND bit 3
    exp_q.push_back(10'h2FF);
    frame(1'b1, 10'h2FF, PAY_W, 1'b1);
    release_ss();
    exp_q.push_back(10'h3AA);
    frame(1'b1, 10'h3AA, PAY_W, 1'b1);
    tx_valid = 1'b1; tx_data = 8'hFF;
    tick();
    tx_valid = 1'b0;
    tick(); tick();
    check("rs_send_miso", MISO, 1);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("rs_miso", MISO, 0);
    check("rs_rx_valid", rx_valid, 0);
    check("rs_addr_pending", dut.addr_pending_q, 0);
    check("rs_busy", busy, 0);
    rst_n = 1'b1;
    release_ss();

    // 5. Read-data with tx_valid held low, then SS_n high
    exp_q.push_back(10'h211);
    frame(1'b1, 10'h211, PAY_W, 1'b1);
    release_ss();
    exp_q.push_back(10'h3C0);
    frame(1'b1, 10'h3C0, PAY_W, 1'b1);
    mo = miso_ones; fec = ferr_count;
    repeat (20) tick();
    check("wt_busy", busy, 1);
    check("wt_miso_quiet", miso_ones - mo, 0);
    tx_valid = 1'b1; tx_data = 8'hFF;
    SS_n = 1'b1;
    tick();
    tx_valid = 1'b0;
    @(negedge clk);
    check("wt_frame_err", frame_err, 1);
    check("wt_busy_idle", busy, 0);
    check("wt_addr_pending", dut.addr_pending_q, 1);
    tick();
    check("wt_ferr_count", ferr_count - fec, 1);
    check("wt_miso_after", miso_ones - mo, 0);

`ifdef SPI_PARITY_EN
    // 6. Parity: wrong bit then correct bit
    rxc = rx_count; fec = ferr_count;
    frame(1'b0, 10'h0A5, PAY_W, 1'b0);
    @(negedge clk);
    check("par_bad_err", frame_err, 1);
    check("par_bad_valid", rx_valid, 0);
    release_ss();
    check("par_bad_rx_count", rx_count - rxc, 0);
    exp_q.push_back(10'h0A5);
    frame(1'b0, 10'h0A5, PAY_W - 1, 1'b1);
    MOSI = 1'b1;
    tick();
    @(negedge clk);
    check("par_no_early_valid", rx_valid, 0);
    MOSI = ~(^10'h0A5);
    tick();
    @(negedge clk);
    check("par_good_valid", rx_valid, 1);
    release_ss();
    check("par_ferr_count", ferr_count - fec, 1);
`endif

    tick();
    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
